// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD arbiter: FSM state encoding and default operand width.
// The timeout feature in gcd_arbiter is enabled with the GCD_TIMEOUT_EN macro.
package gcd_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first set request after ptr,
// wrapping modulo NREQ, so the last winner has the lowest priority next time.
module gcd_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any_valid
);

    int            idx;
    logic [PW-1:0] idx_v;

    // Scan from the farthest candidate down to ptr+1 so the closest hit is written last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = idx[PW-1:0];
            if (req[idx_v]) begin
                winner    = idx_v;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one subtract-loop GCD engine among NREQ requesters with round-robin arbitration.
// Zero operands are answered locally; define GCD_TIMEOUT_EN to abort hung engine jobs.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_x,
    input  logic [NREQ*WIDTH-1:0]   req_y,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    eng_start,
    output logic [WIDTH-1:0]        eng_x,
    output logic [WIDTH-1:0]        eng_y,
    input  logic                    eng_done,
    input  logic [WIDTH-1:0]        eng_gcd
);

    localparam int PW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic              eng_start_q, eng_start_d;
    logic [WIDTH-1:0]  eng_x_q, eng_x_d;
    logic [WIDTH-1:0]  eng_y_q, eng_y_d;
    logic [PW-1:0]     winner;
    logic              any_valid;

`ifdef GCD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    gcd_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Pulse outputs (grant, start, rsp_valid, rsp_err) default low so each lasts one cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = 1'b0;
        eng_start_d = 1'b0;
        eng_x_d     = eng_x_q;
        eng_y_d     = eng_y_q;
`ifdef GCD_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    eng_x_d = req_x[winner*WIDTH +: WIDTH];
                    eng_y_d = req_y[winner*WIDTH +: WIDTH];
                    owner_d = winner;
                    grant_d = onehot(winner);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The engine would never terminate on a zero operand; gcd(0,y)=y.
                if (eng_x_q == '0 || eng_y_q == '0) begin
                    rsp_data_d  = eng_x_q | eng_y_q;
                    rsp_valid_d = onehot(owner_q);
                    state_d     = RESP;
                end else begin
                    eng_start_d = 1'b1;
                    state_d     = WAIT;
`ifdef GCD_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            WAIT: begin
                if (eng_done) begin
                    rsp_data_d  = eng_gcd;
                    rsp_valid_d = onehot(owner_q);
                    state_d     = RESP;
                end
`ifdef GCD_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = onehot(owner_q);
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(NREQ - 1);
            owner_q     <= '0;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_x_q     <= '0;
            eng_y_q     <= '0;
`ifdef GCD_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
            eng_x_q     <= eng_x_d;
            eng_y_q     <= eng_y_d;
`ifdef GCD_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed testbench for gcd_arbiter with a behavioural GCD engine model.
// Timeout checks are compiled in when GCD_TIMEOUT_EN is defined.
module tb_gcd_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_x = '0;
    logic [NREQ*WIDTH-1:0] req_y = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  busy;
    logic                  eng_start;
    logic [WIDTH-1:0]      eng_x;
    logic [WIDTH-1:0]      eng_y;
    logic                  eng_done;
    logic [WIDTH-1:0]      eng_gcd;

    logic                  model_done = 1'b0;
    logic [WIDTH-1:0]      model_gcd = '0;
    logic                  force_done = 1'b0;
    logic                  eng_hang = 1'b0;
    int                    eng_delay = 5;

    int checks = 0;
    int failures = 0;

    assign eng_done = model_done | force_done;
    assign eng_gcd  = model_gcd;

    gcd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .grant     (grant),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_done  (eng_done),
        .eng_gcd   (eng_gcd)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- engine model ----------------
    function automatic logic [WIDTH-1:0] euclid(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    logic             running = 1'b0;
    int               run_cnt = 0;
    logic [WIDTH-1:0] mx = '0;
    logic [WIDTH-1:0] my = '0;

    always @(negedge clk) begin
        model_done = 1'b0;
        if (!reset) begin
            running = 1'b0;
        end else if (running) begin
            if (run_cnt == 0) begin
                model_done = 1'b1;
                model_gcd  = euclid(mx, my);
                running    = 1'b0;
            end else begin
                run_cnt--;
            end
        end else if (eng_start && !eng_hang) begin
            running = 1'b1;
            run_cnt = eng_delay;
            mx      = eng_x;
            my      = eng_y;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        req[i]               = 1'b1;
        req_x[i*WIDTH +: WIDTH] = x;
        req_y[i*WIDTH +: WIDTH] = y;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_valid == '0 && n < 100) begin
            step();
            n++;
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [WIDTH-1:0] tab_x [4] = '{8'd12, 8'd35, 8'd81, 8'd100};
    logic [WIDTH-1:0] tab_y [4] = '{8'd8,  8'd21, 8'd27, 8'd75};
    logic [WIDTH-1:0] tab_g [4] = '{8'd4,  8'd7,  8'd27, 8'd25};
    int               early;

    initial begin
        // reset state
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        chk("reset_outputs", {grant, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_x, eng_y}, 32'h0);

        // single job: 48,18 -> 6
        set_req(0, 8'd48, 8'd18);
        step();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1'b1);
        chk("t1_eng_xy", {eng_x, eng_y}, {8'd48, 8'd18});
        chk("t1_no_start_yet", eng_start, 1'b0);
        req[0] = 1'b0;
        step();
        chk("t1_start", {grant, eng_start}, {4'b0000, 1'b1});
        step();
        chk("t1_start_pulse", eng_start, 1'b0);
        wait_rsp();
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_data", rsp_data, 8'd6);
        chk("t1_rsp_err", rsp_err, 1'b0);
        step();
        chk("t1_idle", {rsp_valid, busy}, 5'b0);

        // all four requesting, two rounds, fresh pointer
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, tab_x[i], tab_y[i]);
            for (int k = 0; k < NREQ; k++) begin
                wait_grant();
                chk($sformatf("t2_r%0d_grant%0d", r, k), grant, 32'(1 << k));
                req[k] = 1'b0;
                wait_rsp();
                chk($sformatf("t2_r%0d_valid%0d", r, k), rsp_valid, 32'(1 << k));
                chk($sformatf("t2_r%0d_data%0d", r, k), rsp_data, tab_g[k]);
                step();
            end
        end

        // zero operands on requester 2
        set_req(2, 8'd0, 8'd35);
        step();
        chk("t3a_grant", grant, 4'b0100);
        req[2] = 1'b0;
        step();
        chk("t3a_no_start", eng_start, 1'b0);
        chk("t3a_rsp", {rsp_valid, rsp_data}, {4'b0100, 8'd35});
        step();
        chk("t3a_idle", {rsp_valid, busy, eng_start}, 6'b0);
        set_req(2, 8'd0, 8'd0);
        step();
        chk("t3b_grant", grant, 4'b0100);
        req[2] = 1'b0;
        step();
        chk("t3b_rsp", {rsp_valid, rsp_data, eng_start}, {4'b0100, 8'd0, 1'b0});
        step();
        chk("t3b_idle", {rsp_valid, busy, eng_start}, 6'b0);

        // reset in WAIT, then stray done
        eng_hang = 1'b1;
        set_req(0, 8'd9, 8'd6);
        wait_grant();
        chk("t4_grant", grant, 4'b0001);
        req[0] = 1'b0;
        step();
        chk("t4_start", eng_start, 1'b1);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t4_reset_outputs", {grant, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_x, eng_y}, 32'h0);
        force_done = 1'b1;
        step();
        chk("t4_no_rsp", {rsp_valid, busy}, 5'b0);
        force_done = 1'b0;
        step();
        chk("t4_still_idle", {rsp_valid, busy}, 5'b0);

        // engine that never finishes
        set_req(1, 8'd10, 8'd4);
        wait_grant();
        chk("t5_grant", grant, 4'b0010);
        req[1] = 1'b0;
        step();
        chk("t5_start", eng_start, 1'b1);
        early = 0;
`ifdef GCD_TIMEOUT_EN
        repeat (TIMEOUT - 1) begin
            step();
            if (rsp_valid != '0) early++;
        end
        chk("t5_no_early_rsp", early, 0);
        step();
        chk("t5_timeout_rsp", {rsp_valid, rsp_err, rsp_data}, {4'b0010, 1'b1, 8'd0});
        step();
        force_done = 1'b1;
        step();
        if (rsp_valid != '0) early++;
        force_done = 1'b0;
        step();
        if (rsp_valid != '0) early++;
        chk("t5_late_done_ignored", {early[3:0], rsp_err, busy}, 6'b0);
`else
        repeat (40) begin
            step();
            if (rsp_valid != '0) early++;
        end
        chk("t5_hang_no_rsp", early, 0);
        chk("t5_hang_busy", busy, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
`endif
        eng_hang = 1'b0;

        // stray done in IDLE, then a normal job
        force_done = 1'b1;
        step();
        chk("t6_stray_done", {rsp_valid, busy}, 5'b0);
        step();
        force_done = 1'b0;
        chk("t6_stray_done2", {rsp_valid, busy}, 5'b0);
        set_req(2, 8'd14, 8'd21);
        wait_grant();
        chk("t6_grant", grant, 4'b0100);
        req[2] = 1'b0;
        wait_rsp();
        chk("t6_rsp", {rsp_valid, rsp_data, rsp_err}, {4'b0100, 8'd7, 1'b0});
        step();
        chk("t6_idle", {rsp_valid, busy}, 5'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
